serpent_round_ctrl: RTL and testbench
=====================================

// Module: serpent_round_ctrl
// PURPOSE
//  Iterative Serpent-128 encryption engine: owns the 128-bit cipher state and sequences 32 rounds
//  through one sboxes instance, selecting the S-box per round and fetching round keys K0..K32.
//  Sits between the XTS tweak/data path (upstream) and the ciphertext sink, next to the key-schedule RAM.
//  One round per clock; 128-bit block in and out over valid/ready handshakes.
// PARAMETERS
//  (none) - rounds fixed at 32, block width fixed at 128
// PORTS
//  i_clk          in   1    clock; all state updates on rising edge
//  i_rst          in   1    synchronous reset, active-high
//  i_valid        in   1    input block valid
//  o_ready        out  1    engine can accept a block (IDLE only)
//  i_data         in   128  plaintext {w3,w2,w1,w0}, w0 = bits [31:0]
//  o_rk_index     out  6    round-key index requested from key store (0..32)
//  i_round_key    in   128  K[o_rk_index], same packing as i_data; valid in same cycle (comb. read)
//  o_valid        out  1    ciphertext valid, held until accepted
//  i_ready        in   1    downstream accepts ciphertext
//  o_data         out  128  ciphertext {w3,w2,w1,w0}
//  o_busy         out  1    high in ROUND or FINAL
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high (i_clk, i_rst).
//  Reset: state->IDLE, round counter=0, state reg=0, o_valid=0, o_ready=1 (comb. from IDLE),
//    o_busy=0, o_rk_index=0, o_data=0. Reset wins over every other event, incl. mid-encryption; block lost.
//  FSM: IDLE -> ROUND -> FINAL -> DONE -> IDLE.
//   IDLE : o_ready=1; i_valid&o_ready at edge: state reg<=i_data, r<=0, ->ROUND.
//   ROUND: o_rk_index=r; sbox index=r[2:0]; X = S_{r mod 8}(state ^ K_r);
//          r<31: state<=LT(X), r<=r+1;  r==31: state<=X (no LT), ->FINAL.
//   FINAL: o_rk_index=32; state<=state ^ K32; ->DONE.
//   DONE : o_valid=1, o_data=state reg (stable); i_ready at edge ->IDLE, o_valid falls.
//  Latency: accepting edge E; rounds on edges E+1..E+32; FINAL on E+33; o_valid high from E+33.
//  Throughput: one block per 35 cycles minimum with i_ready tied high (IDLE costs one cycle; no bypass
//    from DONE to accept - i_valid coincident with i_ready in DONE is accepted the following IDLE cycle).
//  i_valid outside IDLE ignored (o_ready=0); i_data sampled only at accept edge.
//  o_rk_index in IDLE/DONE = 0. o_busy=1 exactly in ROUND and FINAL.
//  Linear transform LT on words X0..X3 (all 32-bit, rotates mod 32, shifts drop bits):
//   X0<<<=13; X2<<<=3; X1^=X0^X2; X3^=X2^(X0<<3); X1<<<=1; X3<<<=7;
//   X0^=X1^X3; X2^=X3^(X1<<7); X0<<<=5; X2<<<=22.
//  S-box step uses sboxes bitslice mapping: nibble i = {w3[i],w2[i],w1[i],w0[i]}.
//  Round counter 5 bits, never wraps: FINAL entered when r==31 completes.
// CONFIGURATION
//  SERPENT_CTRL_ABORT_EN defined: extra input port i_abort (1 bit). i_abort high at an edge in ROUND or
//    FINAL -> IDLE next cycle, r<=0, no o_valid for that block; state reg cleared to 0. i_abort ignored in
//    IDLE and DONE (a completed block must still be drained). i_rst has priority over i_abort.
//  Not defined: port absent; once accepted, a block always runs to DONE unless i_rst.
// TESTING
//  1 Reset: assert i_rst 2 cycles mid-ROUND (r=10) -> next cycle IDLE, o_ready=1, o_valid=0, o_busy=0, o_rk_index=0.
//  2 Latency/index: i_data=0, all K=0, i_ready=1; accept at edge E -> o_rk_index 0,1,...,31,32 on successive
//    cycles, o_valid first high after E+33, data matches golden model for zero key schedule.
//  3 Known-answer: 3 random blocks with key schedule from golden model (key 0x8000...0) -> o_data equals
//    model ciphertext bit-exact; sbox index seen on internal tap = r mod 8 every ROUND cycle.
//  4 Backpressure: i_ready=0 for 20 cycles in DONE -> o_valid and o_data stable; i_valid=1 ignored (o_ready=0);
//    i_ready=1 -> IDLE next cycle, second block accepted one cycle later.
//  5 Back-to-back: i_valid, i_ready tied high, 4 blocks -> accept edges exactly 35 cycles apart, all outputs correct.
//  6 Abort (SERPENT_CTRL_ABORT_EN): i_abort at r=5 -> IDLE next cycle, no o_valid; next block encrypts correctly;
//    i_abort in DONE -> no effect, output still drained.

Source files
------------

// File: rtl/serpent_round_ctrl.sv
// rtl/serpent_round_ctrl.sv - iterative Serpent-128 encryption round controller (optional abort: SERPENT_CTRL_ABORT_EN)

// Bitsliced Serpent S-box layer: nibble i = {w3[i], w2[i], w1[i], w0[i]}.
module sboxes (
    input  logic [2:0]   i_sel,
    input  logic [127:0] i_data,
    output logic [127:0] o_data
);
    logic [63:0] w_tab;

    // Pick the 16-entry table for this round; entry v sits in bits [4v+3:4v].
    always_comb begin
        w_tab = 64'h0;
        case (i_sel)
            3'd0: w_tab = 64'hC90724DEB56A1F83;
            3'd1: w_tab = 64'h43D68EB1A50972CF;
            3'd2: w_tab = 64'h25B04E1DFAC39768;
            3'd3: w_tab = 64'hE57A421D369C8BF0;
            3'd4: w_tab = 64'hD7E9A4526B0C38F1;
            3'd5: w_tab = 64'h176D8E30C9A4B25F;
            3'd6: w_tab = 64'h0A3DF19EB6485C27;
            3'd7: w_tab = 64'h6539AC47B28E0FD1;
            default: w_tab = 64'h0;
        endcase
    end

    // Apply the selected S-box to all 32 bit columns in parallel.
    always_comb begin
        logic [3:0] w_nib;
        logic [3:0] w_res;
        o_data = '0;
        for (int i = 0; i < 32; i++) begin
            w_nib = {i_data[96+i], i_data[64+i], i_data[32+i], i_data[i]};
            w_res = w_tab[{w_nib, 2'b00} +: 4];
            o_data[i]    = w_res[0];
            o_data[32+i] = w_res[1];
            o_data[64+i] = w_res[2];
            o_data[96+i] = w_res[3];
        end
    end
endmodule

module serpent_round_ctrl (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data,
    output logic [5:0]   o_rk_index,
    input  logic [127:0] i_round_key,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data,
    output logic         o_busy
`ifdef SERPENT_CTRL_ABORT_EN
    ,
    input  logic         i_abort
`endif
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       r_fsm;
    logic [127:0] r_state;
    logic [4:0]   r_round;
    logic [5:0]   r_rk_index;
    logic         r_valid;
    logic         r_busy;

    logic         w_abort;
    logic [2:0]   w_sbox_sel;
    logic [127:0] w_sbox_in;
    logic [127:0] w_sbox_out;
    logic [127:0] w_lt;

`ifdef SERPENT_CTRL_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Serpent linear transform on words {x3,x2,x1,x0}.
    function automatic logic [127:0] lin_tf(input logic [127:0] x);
        logic [31:0] x0, x1, x2, x3;
        x0 = x[31:0];
        x1 = x[63:32];
        x2 = x[95:64];
        x3 = x[127:96];
        x0 = rotl32(x0, 13);
        x2 = rotl32(x2, 3);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = rotl32(x1, 1);
        x3 = rotl32(x3, 7);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = rotl32(x0, 5);
        x2 = rotl32(x2, 22);
        return {x3, x2, x1, x0};
    endfunction

    assign w_sbox_sel = r_round[2:0];
    assign w_sbox_in  = r_state ^ i_round_key;

    sboxes u_sboxes (
        .i_sel  (w_sbox_sel),
        .i_data (w_sbox_in),
        .o_data (w_sbox_out)
    );

    assign w_lt = lin_tf(w_sbox_out);

    assign o_ready    = (r_fsm == S_IDLE);
    assign o_rk_index = r_rk_index;
    assign o_valid    = r_valid;
    assign o_busy     = r_busy;
    assign o_data     = r_state;

    // Block sequencer: accept, 32 S-box rounds, final key whitening, hold result until drained.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fsm      <= S_IDLE;
            r_state    <= '0;
            r_round    <= '0;
            r_rk_index <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (i_valid) begin
                        r_state    <= i_data;
                        r_round    <= '0;
                        r_rk_index <= '0;
                        r_busy     <= 1'b1;
                        r_fsm      <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (w_abort) begin
                        r_state    <= '0;
                        r_round    <= '0;
                        r_rk_index <= '0;
                        r_busy     <= 1'b0;
                        r_fsm      <= S_IDLE;
                    end else if (r_round == 5'd31) begin
                        // Last round skips the linear transform; K32 is applied in FINAL.
                        r_state    <= w_sbox_out;
                        r_rk_index <= 6'd32;
                        r_fsm      <= S_FINAL;
                    end else begin
                        r_state    <= w_lt;
                        r_round    <= r_round + 5'd1;
                        r_rk_index <= {1'b0, r_round + 5'd1};
                    end
                end
                S_FINAL: begin
                    if (w_abort) begin
                        r_state    <= '0;
                        r_round    <= '0;
                        r_rk_index <= '0;
                        r_busy     <= 1'b0;
                        r_fsm      <= S_IDLE;
                    end else begin
                        r_state    <= r_state ^ i_round_key;
                        r_rk_index <= '0;
                        r_busy     <= 1'b0;
                        r_valid    <= 1'b1;
                        r_fsm      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_fsm   <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serpent_round_ctrl.sv
// tb/tb_serpent_round_ctrl.sv - randomized self-checking bench for serpent_round_ctrl
module tb_serpent_round_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic         o_ready, o_valid, o_busy;
    logic [5:0]   o_rk_index;
    logic [127:0] o_data;
    logic [127:0] round_key;
    logic [127:0] rk_tab [0:32];
`ifdef SERPENT_CTRL_ABORT_EN
    logic         abort = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    localparam int SB [8][16] = '{
        '{ 3, 8,15, 1,10, 6, 5,11,14,13, 4, 2, 7, 0, 9,12},
        '{15,12, 2, 7, 9, 0, 5,10, 1,11,14, 8, 6,13, 3, 4},
        '{ 8, 6, 7, 9, 3,12,10,15,13, 1,14, 4, 0,11, 5, 2},
        '{ 0,15,11, 8,12, 9, 6, 3,13, 1, 2, 4,10, 7, 5,14},
        '{ 1,15, 8, 3,12, 0,11, 6, 2, 5, 4,10, 9,14, 7,13},
        '{15, 5, 2,11, 4,10, 9,12, 0, 3,14, 8,13, 6, 7, 1},
        '{ 7, 2,12, 5, 8, 4, 6,11,14, 9, 1,15,13, 3,10, 0},
        '{ 1,13,15, 0,14, 8, 2,11, 7, 4,12,10, 9, 3, 5, 6}
    };

    always #5 clk = ~clk;

    assign round_key = (o_rk_index <= 6'd32) ? rk_tab[o_rk_index] : '0;

    serpent_round_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (in_valid),
        .o_ready     (o_ready),
        .i_data      (in_data),
        .o_rk_index  (o_rk_index),
        .i_round_key (round_key),
        .o_valid     (o_valid),
        .i_ready     (out_ready),
        .o_data      (o_data),
        .o_busy      (o_busy)
`ifdef SERPENT_CTRL_ABORT_EN
        ,
        .i_abort     (abort)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        logic [63:0] d;
        d = {v, v};
        return d[63-n -: 32];
    endfunction

    function automatic logic [127:0] sb_apply(input int s, input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            int v;
            int o;
            v = 0;
            if (x[i])    v += 1;
            if (x[32+i]) v += 2;
            if (x[64+i]) v += 4;
            if (x[96+i]) v += 8;
            o = SB[s][v];
            y[i]    = o[0];
            y[32+i] = o[1];
            y[64+i] = o[2];
            y[96+i] = o[3];
        end
        return y;
    endfunction

    function automatic logic [127:0] lt(input logic [127:0] x);
        logic [31:0] w [4];
        for (int j = 0; j < 4; j++) w[j] = x[32*j +: 32];
        w[0] = rol(w[0], 13);
        w[2] = rol(w[2], 3);
        w[1] = w[1] ^ w[0] ^ w[2];
        w[3] = w[3] ^ w[2] ^ (w[0] << 3);
        w[1] = rol(w[1], 1);
        w[3] = rol(w[3], 7);
        w[0] = w[0] ^ w[1] ^ w[3];
        w[2] = w[2] ^ w[3] ^ (w[1] << 7);
        w[0] = rol(w[0], 5);
        w[2] = rol(w[2], 22);
        return {w[3], w[2], w[1], w[0]};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] pt);
        logic [127:0] st;
        st = pt;
        for (int r = 0; r < 32; r++) begin
            st = sb_apply(r % 8, st ^ rk_tab[r]);
            if (r < 31) st = lt(st);
        end
        return st ^ rk_tab[32];
    endfunction

    task automatic make_keys(input logic [127:0] key);
        logic [31:0] w [0:139];
        for (int j = 0; j < 4; j++) w[j] = key[32*j +: 32];
        w[4] = 32'h1;
        w[5] = 32'h0;
        w[6] = 32'h0;
        w[7] = 32'h0;
        for (int i = 0; i < 132; i++)
            w[i+8] = rol(w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9e3779b9 ^ i, 11);
        for (int k = 0; k < 33; k++)
            rk_tab[k] = sb_apply((35 - k) % 8, {w[8+4*k+3], w[8+4*k+2], w[8+4*k+1], w[8+4*k]});
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!o_ready && n < 200) begin
            tick();
            n++;
        end
        if (!o_ready) chk("ready_timeout", o_ready, 1);
    endtask

    // Accept one block, follow every round cycle, then check the ciphertext.
    task automatic run_block(input logic [127:0] pt);
        logic [127:0] exp;
        wait_ready();
        in_data  = pt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp = model(pt);
        for (int k = 0; k <= 32; k++) begin
            chk("busy", o_busy, 1);
            chk("valid_lo", o_valid, 0);
            chk("rk_idx", o_rk_index, k);
            if (k < 32) chk("sbox_sel", dut.w_sbox_sel, k % 8);
            tick();
        end
        chk("valid_hi", o_valid, 1);
        chk("ct", o_data, exp);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] hold, pt2;
        logic [127:0] exp_q [$];
        int acc [$];
        int got;

        for (int k = 0; k < 33; k++) rk_tab[k] = '0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_rk", o_rk_index, 0);
        chk("rst_data", o_data, 0);
        rst = 1'b0;
        tick();

        // Zero block, zero key schedule
        out_ready = 1'b1;
        run_block('0);
        tick();

        // Reset mid-ROUND at r=10
        wait_ready();
        in_data  = rnd128();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("mid_rk10", o_rk_index, 10);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", o_ready, 1);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_rk", o_rk_index, 0);
        tick();

        // Known-answer with real key schedule
        make_keys({1'b1, 127'b0});
        for (int b = 0; b < 3; b++) begin
            run_block(rnd128());
            tick();
        end

        // Backpressure in DONE
        out_ready = 1'b0;
        run_block(rnd128());
        pt2      = rnd128();
        in_data  = pt2;
        in_valid = 1'b1;
        hold     = o_data;
        for (int c = 0; c < 20; c++) begin
            chk("bp_valid", o_valid, 1);
            chk("bp_data", o_data, hold);
            chk("bp_ready", o_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_idle_ready", o_ready, 1);
        chk("bp_idle_valid", o_valid, 0);
        chk("bp_idle_busy", o_busy, 0);
        tick();
        in_valid = 1'b0;
        chk("bp_accept_busy", o_busy, 1);
        chk("bp_accept_rk", o_rk_index, 0);
        repeat (33) tick();
        chk("bp2_valid", o_valid, 1);
        chk("bp2_ct", o_data, model(pt2));
        tick();

        // Back-to-back, 4 blocks
        wait_ready();
        got       = 0;
        in_data   = rnd128();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4 * 35 + 8; c++) begin
            bit took;
            took = 1'b0;
            if (o_ready && in_valid) begin
                acc.push_back(c);
                exp_q.push_back(model(in_data));
                took = 1'b1;
            end
            if (o_valid) begin
                if (exp_q.size() > 0) chk("b2b_ct", o_data, exp_q.pop_front());
                else chk("b2b_extra_valid", o_valid, 0);
                got++;
            end
            tick();
            if (took) begin
                in_data = rnd128();
                if (acc.size() == 4) in_valid = 1'b0;
            end
        end
        chk("b2b_accepts", acc.size(), 4);
        chk("b2b_outputs", got, 4);
        for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", acc[i] - acc[i-1], 35);

`ifdef SERPENT_CTRL_ABORT_EN
        begin
            int seen;
            logic [127:0] p;
            wait_ready();
            in_data  = rnd128();
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (5) tick();
            chk("ab_rk5", o_rk_index, 5);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("ab_ready", o_ready, 1);
            chk("ab_busy", o_busy, 0);
            seen = 0;
            repeat (40) begin
                if (o_valid) seen++;
                tick();
            end
            chk("ab_no_valid", seen, 0);
            run_block(rnd128());
            tick();
            out_ready = 1'b0;
            p = rnd128();
            run_block(p);
            abort = 1'b1;
            tick();
            tick();
            abort = 1'b0;
            chk("ab_done_valid", o_valid, 1);
            chk("ab_done_ct", o_data, model(p));
            out_ready = 1'b1;
            tick();
            chk("ab_done_drain", o_ready, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
